// File: rtl/ifft_16_pkg.sv
// Shared constants, twiddle tables, bit-reversal helper and FSM state type for the 16-point IFFT.
package ifft_16_pkg;

    localparam int unsigned N        = 16;
    localparam int unsigned LOG2N    = 4;
    localparam int unsigned CALC_CYC = (N / 2) * LOG2N;
    localparam int unsigned DW_DEF   = 16;
    localparam int unsigned TW_W_DEF = 16;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // cos/sin(2*pi*t/16) for t = 0..7 in Q2.14 (+1.0 = 16384)
    localparam logic signed [TW_W_DEF-1:0] TW_RE [8] = '{
        16'sd16384, 16'sd15137, 16'sd11585, 16'sd6270,
        16'sd0,     -16'sd6270, -16'sd11585, -16'sd15137
    };
    localparam logic signed [TW_W_DEF-1:0] TW_IM [8] = '{
        16'sd0,     16'sd6270,  16'sd11585, 16'sd15137,
        16'sd16384, 16'sd15137, 16'sd11585, 16'sd6270
    };

    function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

endpackage

// File: rtl/ifft_16_cplx_bfly_r2.sv
// Combinational radix-2 butterfly: A' = (a + c*W) >>> SCALE, C' = (a - c*W) >>> SCALE.
module cplx_bfly_r2
    import ifft_16_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned TW_W  = TW_W_DEF,
    parameter int unsigned SCALE = 1
) (
    input  logic signed [DW-1:0]   i_a_re,
    input  logic signed [DW-1:0]   i_a_im,
    input  logic signed [DW-1:0]   i_c_re,
    input  logic signed [DW-1:0]   i_c_im,
    input  logic signed [TW_W-1:0] i_w_re,
    input  logic signed [TW_W-1:0] i_w_im,
    output logic signed [DW-1:0]   o_a_re_c,
    output logic signed [DW-1:0]   o_a_im_c,
    output logic signed [DW-1:0]   o_c_re_c,
    output logic signed [DW-1:0]   o_c_im_c
);

    localparam int unsigned PW = DW + TW_W + 1;

    logic signed [PW-1:0] w_rr, w_ii, w_ri, w_ir;
    logic signed [PW-1:0] w_p_re_full, w_p_im_full;
    logic signed [DW-1:0] w_p_re, w_p_im;
    logic signed [DW:0]   w_sum_re, w_sum_im, w_dif_re, w_dif_im;

    assign w_rr = PW'(i_c_re) * PW'(i_w_re);
    assign w_ii = PW'(i_c_im) * PW'(i_w_im);
    assign w_ri = PW'(i_c_re) * PW'(i_w_im);
    assign w_ir = PW'(i_c_im) * PW'(i_w_re);

    // Drop the Q2 twiddle fraction bits; arithmetic shift rounds toward -inf
    assign w_p_re_full = w_rr - w_ii;
    assign w_p_im_full = w_ri + w_ir;
    assign w_p_re      = DW'(w_p_re_full >>> (TW_W - 2));
    assign w_p_im      = DW'(w_p_im_full >>> (TW_W - 2));

    assign w_sum_re = (DW+1)'(i_a_re) + (DW+1)'(w_p_re);
    assign w_sum_im = (DW+1)'(i_a_im) + (DW+1)'(w_p_im);
    assign w_dif_re = (DW+1)'(i_a_re) - (DW+1)'(w_p_re);
    assign w_dif_im = (DW+1)'(i_a_im) - (DW+1)'(w_p_im);

    assign o_a_re_c = DW'(w_sum_re >>> SCALE);
    assign o_a_im_c = DW'(w_sum_im >>> SCALE);
    assign o_c_re_c = DW'(w_dif_re >>> SCALE);
    assign o_c_im_c = DW'(w_dif_im >>> SCALE);

endmodule

// File: rtl/ifft_16.sv
// Streaming 16-point radix-2 inverse FFT: load bins bit-reversed, 32 in-place butterfly cycles, stream samples out.
module ifft_16
    import ifft_16_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned TW_W  = TW_W_DEF,
    parameter int unsigned SCALE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_real,
    input  logic signed [DW-1:0] in_imag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_real,
    output logic signed [DW-1:0] out_imag,
    output logic                 out_last,
    output logic                 busy
);

    localparam int unsigned CW = LOG2N + 1;

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic                 r_in_ready, w_in_ready_nxt;
    logic                 r_out_valid, w_out_valid_nxt;
    logic                 r_out_last, w_out_last_nxt;
    logic                 r_busy, w_busy_nxt;
    logic signed [DW-1:0] r_out_re, w_out_re_nxt;
    logic signed [DW-1:0] r_out_im, w_out_im_nxt;
    logic                 w_load_we, w_calc_we;

    logic signed [DW-1:0] r_ram_re [N];
    logic signed [DW-1:0] r_ram_im [N];

    logic [1:0]           w_stage;
    logic [2:0]           w_bfly, w_tw;
    logic [LOG2N-1:0]     w_top, w_bot, w_rd_idx;
    logic signed [TW_W-1:0] w_w_re, w_w_im;
    logic signed [DW-1:0] w_a_re, w_a_im, w_c_re, w_c_im;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_real  = r_out_re;
    assign out_imag  = r_out_im;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

    // Butterfly address/twiddle generation from the shared calc counter
    assign w_stage  = r_cnt[4:3];
    assign w_bfly   = r_cnt[2:0];
    assign w_rd_idx = r_cnt[LOG2N-1:0] + LOG2N'(1);

    always_comb begin
        w_top = '0;
        w_tw  = '0;
        case (w_stage)
            2'd0:    begin w_top = {w_bfly, 1'b0};                  w_tw = 3'd0;               end
            2'd1:    begin w_top = {w_bfly[2:1], 1'b0, w_bfly[0]};  w_tw = {w_bfly[0], 2'b00}; end
            2'd2:    begin w_top = {w_bfly[2], 1'b0, w_bfly[1:0]};  w_tw = {w_bfly[1:0], 1'b0}; end
            default: begin w_top = {1'b0, w_bfly};                  w_tw = w_bfly;             end
        endcase
    end

    assign w_bot  = w_top | LOG2N'(LOG2N'(1) << w_stage);
    assign w_w_re = TW_W'(TW_RE[w_tw]);
    assign w_w_im = TW_W'(TW_IM[w_tw]);

    cplx_bfly_r2 #(.DW(DW), .TW_W(TW_W), .SCALE(SCALE)) u_bfly (
        .i_a_re   (r_ram_re[w_top]),
        .i_a_im   (r_ram_im[w_top]),
        .i_c_re   (r_ram_re[w_bot]),
        .i_c_im   (r_ram_im[w_bot]),
        .i_w_re   (w_w_re),
        .i_w_im   (w_w_im),
        .o_a_re_c (w_a_re),
        .o_a_im_c (w_a_im),
        .o_c_re_c (w_c_re),
        .o_c_im_c (w_c_im)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_LOAD;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_re    <= w_out_re_nxt;
            r_out_im    <= w_out_im_nxt;
            r_out_last  <= w_out_last_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_in_ready_nxt  = r_in_ready;
        w_out_valid_nxt = r_out_valid;
        w_out_re_nxt    = r_out_re;
        w_out_im_nxt    = r_out_im;
        w_out_last_nxt  = r_out_last;
        w_busy_nxt      = r_busy;
        w_load_we       = 1'b0;
        w_calc_we       = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (in_valid && r_in_ready) begin
                    w_load_we = 1'b1;
                    if (r_cnt == CW'(N - 1)) begin
                        w_state_nxt    = S_CALC;
                        w_cnt_nxt      = '0;
                        w_in_ready_nxt = 1'b0;
                        w_busy_nxt     = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            S_CALC: begin
                w_calc_we = 1'b1;
                if (r_cnt == CW'(CALC_CYC - 1)) begin
                    // RAM[0] is final after stage 3 butterfly 0, so preload sample 0 now
                    w_state_nxt     = S_OUT;
                    w_cnt_nxt       = '0;
                    w_out_valid_nxt = 1'b1;
                    w_out_re_nxt    = r_ram_re[0];
                    w_out_im_nxt    = r_ram_im[0];
                    w_out_last_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (r_cnt == CW'(N - 1)) begin
                        w_state_nxt     = S_LOAD;
                        w_cnt_nxt       = '0;
                        w_in_ready_nxt  = 1'b1;
                        w_out_valid_nxt = 1'b0;
                        w_out_re_nxt    = '0;
                        w_out_im_nxt    = '0;
                        w_out_last_nxt  = 1'b0;
                        w_busy_nxt      = 1'b0;
                    end else begin
                        w_cnt_nxt      = r_cnt + CW'(1);
                        w_out_re_nxt   = r_ram_re[w_rd_idx];
                        w_out_im_nxt   = r_ram_im[w_rd_idx];
                        w_out_last_nxt = (r_cnt == CW'(N - 2));
                    end
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // In-place register file: bit-reversed load, butterfly write-back
    always_ff @(posedge clk) begin
        if (w_load_we) begin
            r_ram_re[bitrev4(r_cnt[LOG2N-1:0])] <= in_real;
            r_ram_im[bitrev4(r_cnt[LOG2N-1:0])] <= in_imag;
        end
        if (w_calc_we) begin
            r_ram_re[w_top] <= w_a_re;
            r_ram_im[w_top] <= w_a_im;
            r_ram_re[w_bot] <= w_c_re;
            r_ram_im[w_bot] <= w_c_im;
        end
    end

endmodule

// File: tb/tb_ifft_16.sv
// Directed bench for ifft_16: impulse/tone/DC frames, backpressure, mid-frame reset and back-to-back timing.
module tb_ifft_16;

    logic               clk, reset, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic signed [15:0] in_real, in_imag, out_real, out_imag;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_in_cyc = 0;
    int first_out_cyc = 0;
    int frame_start_cyc = 0;

    typedef struct {
        int re;
        int im;
        bit last;
        int tol;
    } exp_t;
    exp_t exp_q[$];

    // round(1024*cos(2*pi*n/16))
    int COS_T [16] = '{1024, 946, 724, 392, 0, -392, -724, -946,
                       -1024, -946, -724, -392, 0, 392, 724, 946};

    ifft_16 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic chk_tol(input string tag, input logic signed [31:0] obs, input int want, input int tol);
        logic signed [31:0] d;
        d = obs - want;
        n_cmp++;
        assert (((d <= tol) && (d >= -tol)) === 1'b1) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, want, tol);
        end
    endtask

    function automatic int bin_re(input int kind, input int k);
        case (kind)
            0:       return (k == 0) ? 16384 : 0;
            1:       return (k == 1) ? 16384 : 0;
            default: return 2048;
        endcase
    endfunction

    task automatic push_expected(input int kind);
        exp_t e;
        for (int n = 0; n < 16; n++) begin
            e.last = (n == 15);
            case (kind)
                0:       begin e.re = 1024;                   e.im = 0;                     e.tol = 0; end
                1:       begin e.re = COS_T[n];               e.im = COS_T[(n + 12) % 16];  e.tol = 2; end
                default: begin e.re = (n == 0) ? 2048 : 0;    e.im = 0;                     e.tol = 1; end
            endcase
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input int kind, input bit gaps);
        int k = 0;
        int guard = 0;
        push_expected(kind);
        while (k < 16 && guard < 300) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_real  = 16'sh7fff;
            end else begin
                in_valid = 1'b1;
                in_real  = 16'(bin_re(kind, k));
                in_imag  = 16'sd0;
                if (in_ready) begin
                    if (k == 0)  frame_start_cyc = cyc;
                    if (k == 15) last_in_cyc = cyc;
                    k++;
                end
            end
        end
        chk("send_count", k, 16);
        // Junk while busy must be ignored
        @(negedge clk);
        in_valid = 1'b1;
        in_real  = 16'sh7fff;
        in_imag  = 16'sh1234;
    endtask

    task automatic recv_frame(input bit stall, input int count);
        int n = 0;
        int guard = 0;
        bit tog = 1'b0;
        bit held = 1'b0;
        bit seen = 1'b0;
        logic signed [15:0] h_re, h_im;
        logic h_last;
        exp_t e;
        while (n < count && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (held) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_re", out_real, h_re);
                chk("stall_im", out_imag, h_im);
                chk("stall_last", out_last, h_last);
            end
            held = 1'b0;
            out_ready = stall ? tog : 1'b1;
            tog = ~tog;
            if (out_valid) begin
                if (!seen) begin
                    first_out_cyc = cyc;
                    seen = 1'b1;
                end
                chk("busy_out", busy, 1);
                if (out_ready) begin
                    chk("queue_nonempty", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk_tol($sformatf("re[%0d]", n), out_real, e.re, e.tol);
                        chk_tol($sformatf("im[%0d]", n), out_imag, e.im, e.tol);
                        chk($sformatf("last[%0d]", n), out_last, e.last);
                    end
                    n++;
                end else begin
                    held   = 1'b1;
                    h_re   = out_real;
                    h_im   = out_imag;
                    h_last = out_last;
                end
            end
        end
        chk("recv_count", n, count);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_real", out_real, 0);
        chk("rst_out_imag", out_imag, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        exp_q.delete();
    endtask

    initial begin
        int st [3];
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_real   = '0;
        in_imag   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Impulse, with calc-phase status and latency
        send_frame(0, 1'b0);
        chk("calc_busy", busy, 1);
        chk("calc_in_ready", in_ready, 0);
        chk("calc_out_valid", out_valid, 0);
        recv_frame(1'b0, 16);
        chk("latency", first_out_cyc - last_in_cyc, 33);

        // Tone and DC
        send_frame(1, 1'b0);
        recv_frame(1'b0, 16);
        send_frame(2, 1'b0);
        recv_frame(1'b0, 16);

        // Backpressure with input gaps
        for (int f = 0; f < 3; f++) begin
            send_frame(f, 1'b1);
            recv_frame(1'b1, 16);
        end

        // Reset during calc, then a clean impulse frame
        send_frame(1, 1'b0);
        repeat (8) @(negedge clk);
        chk("midcalc_busy", busy, 1);
        do_reset();
        send_frame(0, 1'b0);
        recv_frame(1'b0, 16);

        // Reset while presenting sample 7, then a clean impulse frame
        send_frame(2, 1'b0);
        recv_frame(1'b0, 7);
        do_reset();
        send_frame(0, 1'b0);
        recv_frame(1'b0, 16);

        // Back-to-back frames at full rate
        for (int f = 0; f < 3; f++) begin
            send_frame(f, 1'b0);
            st[f] = frame_start_cyc;
            recv_frame(1'b0, 16);
            chk("latency_b2b", first_out_cyc - last_in_cyc, 33);
        end
        chk("period_1", st[1] - st[0], 64);
        chk("period_2", st[2] - st[1], 64);

        @(negedge clk);
        in_valid = 1'b0;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
